// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) multipliers and the MixColumns engine FSM states.
// Inverse-direction multipliers exist only when MIXCOL_INV_EN is defined.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;
  localparam int BYTE_W  = 8;
  localparam logic [BYTE_W-1:0] RED_POLY = 8'h1b;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? RED_POLY : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul2(input logic [BYTE_W-1:0] x);
    return xtime(x);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul3(input logic [BYTE_W-1:0] x);
    return xtime(x) ^ x;
  endfunction

`ifdef MIXCOL_INV_EN
  // Inverse coefficients are built from x*8, x*4 and x*2 partial products.
  function automatic logic [BYTE_W-1:0] gmul9(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul11(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul13(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul14(input logic [BYTE_W-1:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns transform of one 32-bit column (row 0 in the top byte).
// With MIXCOL_INV_EN defined, inv_i selects InvMixColumns; otherwise inv_i is ignored.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             inv_i,
  output logic [COL_W-1:0] col_o
);

  logic [BYTE_W-1:0] a   [4];
  logic [BYTE_W-1:0] fwd [4];
  logic [BYTE_W-1:0] res [4];

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r]   = col_i[COL_W-1-BYTE_W*r -: BYTE_W];
    assign fwd[r] = gmul2(a[r]) ^ gmul3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
`ifdef MIXCOL_INV_EN
    logic [BYTE_W-1:0] invB;
    assign invB   = gmul14(a[r]) ^ gmul11(a[(r+1)%4]) ^ gmul13(a[(r+2)%4]) ^ gmul9(a[(r+3)%4]);
    assign res[r] = inv_i ? invB : fwd[r];
`else
    assign res[r] = fwd[r];
`endif
  end

`ifndef MIXCOL_INV_EN
  logic unused_inv;
  assign unused_inv = inv_i;
`endif

  assign col_o = {res[0], res[1], res[2], res[3]};

endmodule

// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready in and out.
// Define MIXCOL_INV_EN to add the InvMixColumns datapath and the in_inv mode register.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int STATE_W        = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);
  import aes_pkg::*;

  localparam int NUM_GROUPS = (COLS_PER_CYCLE > 0) ? 4 / COLS_PER_CYCLE : 1;
  localparam logic [1:0] LAST_GROUP = 2'(NUM_GROUPS - 1);

  if ((COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) || STATE_W != 128)
  begin : g_badParam
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4 and STATE_W must be 128");
  end

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [STATE_W-1:0] result_q, result_d;
  logic               accept;
  logic               lastGroup;
  logic               modeInv;

  logic [1:0]       colIdx [COLS_PER_CYCLE];
  logic [COL_W-1:0] colIn  [COLS_PER_CYCLE];
  logic [COL_W-1:0] colOut [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
  logic mode_q, mode_d;
  assign modeInv = mode_q;
`else
  logic unused_inInv;
  assign modeInv      = 1'b0;
  assign unused_inInv = in_inv;
`endif

  // Group k covers columns k*C .. k*C+C-1; the 2-bit truncation is the column number.
  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign colIdx[j] = 2'(32'(cnt_q) * 32'(COLS_PER_CYCLE) + 32'(j));
    assign colIn[j]  = work_q[{colIdx[j], 5'd0} +: COL_W];
    mix_single_column u_col (
      .col_i (colIn[j]),
      .inv_i (modeInv),
      .col_o (colOut[j])
    );
  end

  assign lastGroup = (cnt_q == LAST_GROUP);
  assign out_valid = (state_q == DONE);
  assign out_state = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    in_ready = 1'b0;
    accept   = 1'b0;
`ifdef MIXCOL_INV_EN
    mode_d   = mode_q;
`endif
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          result_d[{colIdx[j], 5'd0} +: COL_W] = colOut[j];
        end
        if (lastGroup) begin
          state_d = DONE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      DONE: begin
        // Output handoff and the next accept share this cycle.
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept  = 1'b1;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      work_d = in_state;
      cnt_d  = 2'd0;
`ifdef MIXCOL_INV_EN
      mode_d = in_inv;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      work_q   <= '0;
      result_q <= '0;
`ifdef MIXCOL_INV_EN
      mode_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
`ifdef MIXCOL_INV_EN
      mode_q   <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine with instances at 1, 2 and 4 columns per cycle.
// Inverse and round-trip vectors run when MIXCOL_INV_EN is defined.
module tb_mix_columns_engine;

  localparam logic [127:0] COL_A_IN   = 128'h00000000_00000000_00000000_db135345;
  localparam logic [127:0] COL_A_OUT  = 128'h00000000_00000000_00000000_8e4da1bc;
  localparam logic [127:0] VEC_B_IN   = 128'hd4d4d4d5_c6c6c6c6_01010101_f20a225c;
  localparam logic [127:0] VEC_B_OUT  = 128'hd5d5d7d6_c6c6c6c6_01010101_9fdc589d;

  logic         clk = 1'b0;
  logic         rstN;
  logic         inValid  [3];
  logic         inReady  [3];
  logic [127:0] inState  [3];
  logic         inInv    [3];
  logic         outValid [3];
  logic         outReady [3];
  logic [127:0] outState [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_state(inState[0]), .in_inv(inInv[0]), .out_valid(outValid[0]),
    .out_ready(outReady[0]), .out_state(outState[0])
  );
  mix_columns_engine #(.COLS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_state(inState[1]), .in_inv(inInv[1]), .out_valid(outValid[1]),
    .out_ready(outReady[1]), .out_state(outState[1])
  );
  mix_columns_engine #(.COLS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rstN), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_state(inState[2]), .in_inv(inInv[2]), .out_valid(outValid[2]),
    .out_ready(outReady[2]), .out_state(outState[2])
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait: counts edges after the accept edge until out_valid rises.
  task automatic waitResult(input int u, input int expLat, input string tag);
    int lat;
    lat = 0;
    while (!outValid[u] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 128'(lat), 128'(expLat));
  endtask

  task automatic applyStimulus(input int u, input logic [127:0] s, input logic inv,
                               input int expLat, input string tag, output logic [127:0] res);
    int waitCnt;
    @(negedge clk);
    inValid[u] = 1'b1;
    inState[u] = s;
    inInv[u]   = inv;
    waitCnt = 0;
    while (!inReady[u] && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    @(posedge clk); #1;
    inValid[u] = 1'b0;
    inInv[u]   = 1'b0;
    waitResult(u, expLat, tag);
    res = outState[u];
    @(negedge clk);
    outReady[u] = 1'b1;
    @(posedge clk); #1;
    outReady[u] = 1'b0;
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] fwd;
    logic [127:0] seed;
    for (int u = 0; u < 3; u++) begin
      inValid[u]  = 1'b0;
      inState[u]  = '0;
      inInv[u]    = 1'b0;
      outReady[u] = 1'b0;
    end
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      checkOutput("reset in_ready", 128'(inReady[u]), 128'd1);
      checkOutput("reset out_valid", 128'(outValid[u]), 128'd0);
      checkOutput("reset out_state", outState[u], 128'd0);
    end
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(0, COL_A_IN, 1'b0, 4, "c1 fwd", res);
    checkOutput("c1 fwd value", res, COL_A_OUT);
    applyStimulus(2, VEC_B_IN, 1'b0, 1, "c4 fwd", res);
    checkOutput("c4 fwd value", res, VEC_B_OUT);
    applyStimulus(1, VEC_B_IN, 1'b0, 2, "c2 fwd", res);
    checkOutput("c2 fwd value", res, VEC_B_OUT);

`ifdef MIXCOL_INV_EN
    applyStimulus(0, COL_A_OUT, 1'b1, 4, "c1 inv", res);
    checkOutput("c1 inv value", res, COL_A_IN);
    applyStimulus(2, VEC_B_OUT, 1'b1, 1, "c4 inv", res);
    checkOutput("c4 inv value", res, VEC_B_IN);
    for (int i = 0; i < 100; i++) begin
      seed = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus(2, seed, 1'b0, 1, "rt fwd", fwd);
      applyStimulus(2, fwd, 1'b1, 1, "rt inv", res);
      checkOutput("rt identity", res, seed);
    end
`else
    applyStimulus(0, COL_A_IN, 1'b1, 4, "c1 inv ignored", res);
    checkOutput("c1 inv ignored value", res, COL_A_OUT);
`endif

    // Backpressure on the 2-column engine, then an overlapped accept.
    @(negedge clk);
    inValid[1] = 1'b1;
    inState[1] = VEC_B_IN;
    @(posedge clk); #1;
    inValid[1] = 1'b0;
    waitResult(1, 2, "hs first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("hs out_state stable", outState[1], VEC_B_OUT);
      checkOutput("hs in_ready low", 128'(inReady[1]), 128'd0);
      checkOutput("hs out_valid held", 128'(outValid[1]), 128'd1);
    end
    @(negedge clk);
    inValid[1]  = 1'b1;
    inState[1]  = COL_A_IN;
    outReady[1] = 1'b1;
    #1;
    checkOutput("hs in_ready comb", 128'(inReady[1]), 128'd1);
    @(posedge clk); #1;
    inValid[1]  = 1'b0;
    outReady[1] = 1'b0;
    checkOutput("hs busy after overlap", 128'(outValid[1]), 128'd0);
    waitResult(1, 2, "hs second");
    checkOutput("hs second value", outState[1], COL_A_OUT);
    @(negedge clk);
    outReady[1] = 1'b1;
    @(posedge clk); #1;
    outReady[1] = 1'b0;

    // Reset while the 1-column engine is at group 2.
    @(negedge clk);
    inValid[0] = 1'b1;
    inState[0] = VEC_B_IN;
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("rst pre out_valid", 128'(outValid[0]), 128'd0);
    end
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("rst in_ready", 128'(inReady[0]), 128'd1);
    checkOutput("rst out_state", outState[0], 128'd0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("rst post out_valid", 128'(outValid[0]), 128'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Sequential, parameterised AES MixColumns / InvMixColumns engine. It accepts a 128-bit state over a valid/ready handshake and processes `COLS_PER_CYCLE` columns per clock, so area can be traded for latency. The result is returned over a second valid/ready handshake. It sits between the ShiftRows and AddRoundKey stages of the iterative round datapath, and serves both the encrypt and decrypt paths.

## Interface
Parameters:
- `COLS_PER_CYCLE`, default 1: columns transformed per cycle. Legal values are 1, 2 and 4; any other value fails elaboration.
- `STATE_W`, default 128: state width. Fixed at 128; the parameter exists for package consistency only.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_valid`, input, 1: input state is valid.
- `in_ready`, output, 1: engine can accept a state.
- `in_state`, input, 128: input state. Column c is at bits [32c+:32]. Within a column, row 0 is [32c+24+:8], row 1 is [32c+16+:8], row 2 is [32c+8+:8] and row 3 is [32c+:8].
- `in_inv`, input, 1: 1 selects InvMixColumns; sampled on accept.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: downstream accepts the result.
- `out_state`, output, 128: result, same layout as `in_state`.

## Operation
- N = 4 / `COLS_PER_CYCLE` compute cycles per state.
- Forward column coefficients, row r: 02·a_r ⊕ 03·a_(r+1) ⊕ a_(r+2) ⊕ a_(r+3), with indices mod 4.
- Inverse column coefficients, row r: 0e·a_r ⊕ 0b·a_(r+1) ⊕ 0d·a_(r+2) ⊕ 09·a_(r+3).
- All arithmetic is in GF(2^8) modulo 0x11b. xtime(x) = (x<<1) ⊕ (x[7] ? 0x1b : 0), kept at 8 bits.
- The FSM has three states:
  - IDLE to BUSY when `in_valid` && `in_ready`. On this transition `in_state` is captured into the work register, `in_inv` into the mode register, and the column counter is cleared.
  - BUSY: each cycle the column group at counter k (columns k·C … k·C+C−1) is transformed and written into the result register, then k increments. After the group at k = N−1, the FSM moves to DONE.
  - DONE holds `out_valid` = 1 and keeps `out_state` stable until `out_ready`. On `out_ready`:
    - if `in_valid` is also high, it accepts a new state and goes to BUSY;
    - otherwise it goes to IDLE.
- `in_ready` = (IDLE) || (DONE && `out_ready`). No input is accepted while BUSY.
- `in_state` and `in_inv` are ignored except on an accept cycle.
- An identity check must hold: inverse(forward(s)) == s for every s.

## Timing
- Reset values: `in_ready` = 1 (FSM in IDLE), `out_valid` = 0, `out_state` = 0. The counter, work register and mode register are all 0.
- Latency: `out_valid` rises N clock edges after the accepting edge. That is 4, 2 or 1 cycles for C = 1, 2 or 4.
- Throughput: one state per N+1 cycles with continuous `in_valid` and `out_ready`, because the DONE→BUSY transition overlaps output with the next accept.
- `out_state` is registered. There is no combinational path from `in_*` to `out_*`, nor from `out_ready` to `out_state`.
- `in_ready` is combinational from `out_ready` in DONE only.
- Reset asserted in any state returns the engine to reset values on the next edge. Any partially computed state is discarded and never presented.
- Backpressure: `out_ready` held low keeps DONE indefinitely with `out_state` stable and `in_ready` = 0.

## Configuration
- `MIXCOL_INV_EN` defined: inverse datapath and mode register are present, and `in_inv` selects the direction.
- Not defined:
  - inverse logic is removed and `in_inv` is ignored, so behaviour is always forward;
  - the mode register is absent;
  - all timing is unchanged.

## Structure
- Shared package `aes_pkg`:
  - `STATE_W`, `COL_W` = 32, `BYTE_W` = 8, the reduction constant 8'h1b;
  - functions `xtime`, `gmul2`, `gmul3`, plus `gmul9`, `gmul11`, `gmul13`, `gmul14` (the inverse multipliers, guarded by `MIXCOL_INV_EN`);
  - FSM state enum {IDLE, BUSY, DONE}.
- One sub-module, `mix_single_column`: combinational, 32-bit in/out, with an `inv` input. It is instantiated `COLS_PER_CYCLE` times. The top level holds the FSM, counter, column mux and result register.

## Test plan
- Forward, C=1: column 0 = {db,13,53,45} (row0..row3), the rest zero → column 0 = {8e,4d,a1,bc}. `out_valid` rises 4 edges after accept.
- Forward, C=4: columns {f2,0a,22,5c}, {01,01,01,01}, {c6,c6,c6,c6}, {d4,d4,d4,d5} → {9f,dc,58,9d}, {01,01,01,01}, {c6,c6,c6,c6}, {d5,d5,d7,d6}. Latency is 1.
- Inverse (`MIXCOL_INV_EN`): input column {8e,4d,a1,bc} with `in_inv` = 1 → {db,13,53,45}. Repeat with 100 random states: forward then inverse returns the original.
- Handshake, C=2: hold `out_ready` = 0 for 10 cycles → `out_state` is stable and `in_ready` = 0. Then pulse `out_ready` with `in_valid` high → the new state is accepted in the same cycle, and the next `out_valid` follows 2 edges later.
- Reset mid-operation: drop `rst_n` at counter k = 2 (C=1) → `out_valid` is never asserted for that state, and all outputs are at reset values after the edge.
- Build without `MIXCOL_INV_EN`: `in_inv` = 1 with {db,13,53,45} → forward result {8e,4d,a1,bc}.
